tribus_arbiter: RTL and testbench

Round-robin arbiter and enable sequencer for a shared tristate bus built from `bufif1`/`nmos`-style drivers. Each requester's driver enable comes from this block. The block guarantees at most one enable is high at any time and inserts a programmable all-off turnaround gap between bus owners, so the bus floats (`z`) instead of contending (`x`). It sits between the requesting units and the tristate driver bank on the shared net.

---
 rtl/tribus_arbiter_if.sv | 31 +++
 rtl/tribus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_tribus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tribus_arbiter_if.sv
// Bus-side signal bundle for tribus_arbiter: request lines in, owner
// enables and status out. The arbiter uses the master modport, the
// requesting units / driver bank use the slave modport.
interface tribus_arbiter_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic [N-1:0] oe;
   logic         busy;
   logic         preempt;
   logic [2:0]   owner;

   modport master (
      input  req,
      output grant,
      output oe,
      output busy,
      output preempt,
      output owner
   );

   modport slave (
      output req,
      input  grant,
      input  oe,
      input  busy,
      input  preempt,
      input  owner
   );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin owner selection and driver-enable sequencing for a shared
// tristate net. At most one enable is ever high, and every change of
// owner passes through TURN_CYC all-off cycles so the net floats rather
// than contends.
// Optional feature: define TRIBUS_TIMEOUT_EN to force release of an owner
// that has held the bus MAX_HOLD cycles while someone else is waiting.
module tribus_arbiter #(
   parameter int unsigned N        = 4,
   parameter int unsigned TURN_CYC = 1,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   tribus_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_TURN  = 2'd2
   } state_e;

   localparam logic [N-1:0] ONE       = N'(1);
   localparam logic [3:0]   TURN_LAST = 4'(TURN_CYC - 1);

   state_e       state_q, state_d;
   logic [N-1:0] grant_q, grant_d;
   logic [2:0]   owner_q, owner_d;
   logic [2:0]   ptr_q, ptr_d;
   logic [3:0]   turn_q, turn_d;
   logic [2:0]   win;
   logic         any_req;
   logic         own_req;
   logic         other_req;
   logic         force_rel;

   // First set request at or above p, wrapping modulo N.
   function automatic logic [2:0] rr_pick(input logic [N-1:0] r, input logic [2:0] p);
      logic [2:0]  w;
      logic        found;
      int unsigned idx;
      w     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (32'(p) + i) % N;
         if (!found && (((r >> idx) & ONE) != '0)) begin
            found = 1'b1;
            w     = idx[2:0];
         end
      end
      return w;
   endfunction

   // Request decode; grant_q is one-hot in DRIVE so it doubles as the owner mask.
   always_comb begin
      win       = rr_pick(bus.req, ptr_q);
      any_req   = |bus.req;
      own_req   = |(bus.req & grant_q);
      other_req = |(bus.req & ~grant_q);
   end

`ifdef TRIBUS_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q, hold_d;
   logic       preempt_q, preempt_d;

   // Hold counter: zero outside a continuing ownership, saturating while held.
   always_comb begin
      hold_d = '0;
      if (state_q == ST_DRIVE && state_d == ST_DRIVE) begin
         hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 8'd1;
      end
      force_rel = (state_q == ST_DRIVE) && (hold_q == HOLD_LAST) && other_req;
      preempt_d = force_rel && own_req;
   end

   // Hold counter and preempt pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end

   assign bus.preempt = preempt_q;
`else
   assign force_rel   = 1'b0;
   assign bus.preempt = 1'b0;
`endif

   // Next-state: arbitration, release and turnaround sequencing.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      turn_d  = turn_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_DRIVE;
               grant_d = ONE << win;
               owner_d = win;
            end
         end
         ST_DRIVE: begin
            if (!own_req || force_rel) begin
               state_d = ST_TURN;
               grant_d = '0;
               ptr_d   = (owner_q == 3'(N - 1)) ? 3'd0 : owner_q + 3'd1;
               turn_d  = '0;
            end
         end
         ST_TURN: begin
            if (turn_q == TURN_LAST) begin
               if (any_req) begin
                  state_d = ST_DRIVE;
                  grant_d = ONE << win;
                  owner_d = win;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               turn_d = turn_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers; async reset drops every enable immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         turn_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         turn_q  <= turn_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.oe    = grant_q;
   assign bus.busy  = (state_q == ST_DRIVE);
   assign bus.owner = owner_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: two instances (1-cycle and 3-cycle gaps) see
// the same request stream and are compared every cycle against an
// ownership/gap model, plus directed scenarios with literal expectations.
module tb_tribus_arbiter;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b1111;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   tribus_arbiter_if #(.N(4)) bif1 ();
   tribus_arbiter_if #(.N(4)) bif3 ();
   assign bif1.req = req;
   assign bif3.req = req;

   tribus_arbiter #(.N(4), .TURN_CYC(1), .MAX_HOLD(MAXH)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif1.master)
   );

   tribus_arbiter #(.N(4), .TURN_CYC(3), .MAX_HOLD(MAXH)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif3.master)
   );

   // Model per instance: current owner (-1 none), silent cycles still owed,
   // where the next scan starts, cycles driven so far, last owner.
   int m_own [2];
   int m_gap [2];
   int m_start [2];
   int m_held [2];
   int m_pre [2];
   int m_last [2];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int m_pick(input logic [3:0] r, input int start);
      for (int i = 0; i < 4; i++) begin
         if (r[(start + i) % 4]) return (start + i) % 4;
      end
      return -1;
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         m_own[d] = -1; m_gap[d] = 0; m_start[d] = 0;
         m_held[d] = 0; m_pre[d] = 0; m_last[d] = 0;
      end
   endtask

   task automatic m_step(input int d, input logic [3:0] r);
      int   w;
      logic forced;
      int   tc;
      tc       = (d == 0) ? 1 : 3;
      m_pre[d] = 0;
      if (m_own[d] >= 0) begin
         forced = 1'b0;
`ifdef TRIBUS_TIMEOUT_EN
         forced = r[m_own[d]] && (m_held[d] >= MAXH) && ((r & ~(4'b0001 << m_own[d])) != 4'b0);
`endif
         if (!r[m_own[d]] || forced) begin
            m_pre[d]   = forced ? 1 : 0;
            m_start[d] = (m_own[d] + 1) % 4;
            m_own[d]   = -1;
            m_gap[d]   = tc;
         end else begin
            m_held[d]++;
         end
      end else begin
         if (m_gap[d] > 0) m_gap[d]--;
         if (m_gap[d] == 0) begin
            w = m_pick(r, m_start[d]);
            if (w >= 0) begin
               m_own[d]  = w;
               m_last[d] = w;
               m_held[d] = 1;
            end
         end
      end
   endtask

   task automatic cmp_dut(input int d, input logic [3:0] g, input logic [3:0] oe,
                          input logic b, input logic p, input logic [2:0] own);
      logic [3:0] eg;
      string      tag;
      tag = (d == 0) ? "tc1" : "tc3";
      eg  = (m_own[d] >= 0) ? (4'b0001 << m_own[d]) : 4'b0000;
      chk({tag, "_grant"}, g, eg);
      chk({tag, "_oe"}, oe, eg);
      chk({tag, "_busy"}, b, (m_own[d] >= 0) ? 1 : 0);
      chk({tag, "_preempt"}, p, m_pre[d]);
      chk({tag, "_owner"}, own, m_last[d]);
      chk({tag, "_oe_onehot"}, ($countones(oe) <= 1) ? 1 : 0, 1);
   endtask

   // Model advance on every clock edge or async reset.
   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else begin
            m_step(0, req);
            m_step(1, req);
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         cmp_dut(0, bif1.grant, bif1.oe, bif1.busy, bif1.preempt, bif1.owner);
         cmp_dut(1, bif3.grant, bif3.oe, bif3.busy, bif3.preempt, bif3.owner);
      end
   end

   task automatic do_reset(input logic [3:0] r);
      #2;
      rst_n = 1'b0;
      req   = r;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic window(input int n, input bit restore, input logic [3:0] rv,
                         output int z1, output int z3);
      z1 = 0;
      z3 = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (c == 0 && restore) req = rv;
         if (bif1.grant == 4'b0000) z1++;
         if (bif3.grant == 4'b0000) z3++;
      end
   endtask

   initial begin
      int         z1, z3, held1, pre1, pre3, h;
      logic [3:0] flip, saved;

      // Reset with every request high.
      repeat (2) @(negedge clk);
      chk("rst_grant1", bif1.grant, 0);
      chk("rst_oe3", bif3.oe, 0);
      chk("rst_owner1", bif1.owner, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_first_grant1", bif1.grant, 4'b0001);
      chk("rst_first_grant3", bif3.grant, 4'b0001);

      // Round robin on the 1-cycle-gap instance.
      for (int k = 0; k < 5; k++) begin
         chk("rr_owner", bif1.owner, k % 4);
         chk("rr_grant", bif1.grant, 1 << (k % 4));
         if (k < 4) begin
            repeat (2) @(negedge clk);
            req[k % 4] = 1'b0;
            z1 = 0;
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               if (c == 0) req[k % 4] = 1'b1;
               if (bif1.grant != 4'b0000) break;
               z1++;
            end
            chk("rr_gap", z1, 1);
         end
      end

      // Turnaround: owner 2 releases while requester 0 waits.
      @(negedge clk);
      do_reset(4'b0100);
      @(negedge clk);
      chk("turn_owner2_grant3", bif3.grant, 4'b0100);
      req = 4'b0001;
      window(6, 1'b0, 4'b0000, z1, z3);
      chk("turn_gap3", z3, 3);
      chk("turn_gap1", z1, 1);
      chk("turn_next_grant3", bif3.grant, 4'b0001);
      chk("turn_next_grant1", bif1.grant, 4'b0001);

      // Lone re-request by requester 1.
      do_reset(4'b0010);
      @(negedge clk);
      chk("lone_grant", bif3.grant, 4'b0010);
      @(negedge clk);
      req = 4'b0000;
      window(6, 1'b1, 4'b0010, z1, z3);
      chk("lone_gap3", z3, 3);
      chk("lone_gap1", z1, 1);
      chk("lone_regrant3", bif3.grant, 4'b0010);
      chk("lone_owner3", bif3.owner, 1);

`ifdef TRIBUS_TIMEOUT_EN
      // Forced release of owner 0 while requester 3 waits.
      do_reset(4'b0001);
      @(negedge clk);
      chk("to_grant0", bif1.grant, 4'b0001);
      req   = 4'b1001;
      held1 = 1;
      pre1  = 0;
      pre3  = 0;
      for (int c = 2; c <= 9; c++) begin
         @(negedge clk);
         if (bif1.grant == 4'b0001) held1++;
         pre1 += int'(bif1.preempt);
         pre3 += int'(bif3.preempt);
         if (c == 5) chk("to_preempt_gap", bif1.preempt, 1);
         if (c == 6) chk("to_grant3_tc1", bif1.grant, 4'b1000);
         if (c == 8) chk("to_grant3_tc3", bif3.grant, 4'b1000);
      end
      chk("to_hold_cycles", held1, 4);
      chk("to_preempt_count1", pre1, 1);
      chk("to_preempt_count3", pre3, 1);

      // No competitor: ownership persists, no preempt.
      do_reset(4'b0001);
      h = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bif1.grant == 4'b0001 && bif3.grant == 4'b0001 &&
             !bif1.preempt && !bif3.preempt) h++;
      end
      chk("to_long_hold", h, 25);
`endif

      // Asynchronous reset in the middle of a DRIVE cycle.
      do_reset(4'b0001);
      @(negedge clk);
      @(posedge clk);
      #2;
      chk("async_before_oe1", bif1.oe, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("async_oe1", bif1.oe, 0);
      chk("async_oe3", bif3.oe, 0);
      chk("async_busy1", bif1.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic with sub-cycle glitches and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         flip = 4'b0000;
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(3) == 0) flip[b] = 1'b1;
         end
         req = req ^ flip;
         if ($urandom_range(7) == 0) begin
            saved = req;
            #1 req = req ^ 4'($urandom_range(15));
            #1 req = saved;
         end
         if ($urandom_range(599) == 0) begin
            #1 rst_n = 1'b0;
         end
      end
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
